// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between a single manager and the memory subordinate.
interface ahb_lite_mem_slave_if;
  logic        hsel_f;
  logic [31:0] haddr_f;
  logic [1:0]  htrans_f;
  logic        hwrite_f;
  logic [2:0]  hsize_f;
  logic [2:0]  hburst_f;
  logic [3:0]  hprot_f;
  logic [31:0] hwdata_f;
  logic        error_f;
  logic [31:0] hrdata_f;
  logic        hready_f;
  logic        hresp_f;

  modport master (
    output hsel_f, haddr_f, htrans_f, hwrite_f, hsize_f, hburst_f, hprot_f, hwdata_f, error_f,
    input  hrdata_f, hready_f, hresp_f
  );

  modport slave (
    input  hsel_f, haddr_f, htrans_f, hwrite_f, hsize_f, hburst_f, hprot_f, hwdata_f, error_f,
    output hrdata_f, hready_f, hresp_f
  );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite subordinate RAM: byte-lane writes, programmable wait states and the
// two-cycle ERROR response for illegal or error-injected transfers.
module ahb_lite_mem_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                 hclk_f,
  input logic                 hreset_f,
  ahb_lite_mem_slave_if.slave bus
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e        r_state;
  logic [3:0]    r_cnt;
  logic          r_hready;
  logic          r_hresp;
  logic [31:0]   r_hrdata;
  logic          r_pend_wr;
  logic [AW-1:0] r_waddr;
  logic [3:0]    r_be;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_off;
  logic          w_in_range;
  logic          w_misalign;
  logic          w_err;
  logic          w_accept;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_fwd;
  logic          w_unused_bits;

  assign w_off      = bus.haddr_f - ADDR_BASE;
  assign w_in_range = (bus.haddr_f >= ADDR_BASE) && ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[AW+1:2];
  assign w_accept   = r_hready && bus.hsel_f && bus.htrans_f[1];
  assign w_commit   = r_pend_wr && r_hready;
  assign w_err      = (bus.hsize_f > 3'd2) || w_misalign || !w_in_range || bus.error_f;

  assign w_unused_bits = ^{bus.hburst_f, bus.hprot_f, w_off};

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    case (bus.hsize_f)
      3'd0: begin
        w_be = 4'b0001 << bus.haddr_f[1:0];
      end
      3'd1: begin
        w_misalign = bus.haddr_f[0];
        w_be       = bus.haddr_f[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        w_misalign = (bus.haddr_f[1:0] != 2'b00);
      end
      default: begin
        w_be = 4'b0000;
      end
    endcase
  end

  // Read data seen on an accept edge includes a write committing on that same edge.
  always_comb begin
    w_fwd = r_mem[w_idx];
    if (w_commit && (r_waddr == w_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) w_fwd[8*b +: 8] = bus.hwdata_f[8*b +: 8];
      end
    end
  end

  // RAM is deliberately not reset so contents survive a bus reset.
  always_ff @(posedge hclk_f) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_waddr][8*b +: 8] <= bus.hwdata_f[8*b +: 8];
      end
    end
  end

  always_ff @(posedge hclk_f or posedge hreset_f) begin
    if (hreset_f) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_hready  <= 1'b1;
      r_hresp   <= 1'b0;
      r_hrdata  <= 32'd0;
      r_pend_wr <= 1'b0;
      r_waddr   <= '0;
      r_be      <= 4'b0000;
    end else begin
      if (w_commit) r_pend_wr <= 1'b0;
      case (r_state)
        StIdle, StErr2: begin
          if (w_accept && w_err) begin
            r_state   <= StErr1;
            r_hready  <= 1'b0;
            r_hresp   <= 1'b1;
            r_hrdata  <= 32'd0;
            r_pend_wr <= 1'b0;
          end else if (w_accept) begin
            if (bus.hwrite_f) begin
              r_pend_wr <= 1'b1;
              r_waddr   <= w_idx;
              r_be      <= w_be;
            end else begin
              r_hrdata  <= w_fwd;
            end
            r_hresp <= 1'b0;
            if (WAIT_INIT != 4'd0) begin
              r_state  <= StWait;
              r_cnt    <= WAIT_INIT;
              r_hready <= 1'b0;
            end else begin
              r_state  <= StIdle;
              r_hready <= 1'b1;
            end
          end else begin
            r_state  <= StIdle;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state  <= StIdle;
            r_hready <= 1'b1;
          end
        end
        StErr1: begin
          r_state  <= StErr2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          r_state  <= StIdle;
          r_hready <= 1'b1;
          r_hresp  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hready_f = r_hready;
  assign bus.hresp_f  = r_hresp;
  assign bus.hrdata_f = r_hrdata;

endmodule

// File: doc/ahb_lite_mem_slave.md
# ahb_lite_mem_slave

AHB-Lite subordinate memory that consumes the transfers produced by the bench driver on the `dut_if` bus and returns `hrdata_f`/`hready_f`/`hresp_f` to the monitor. It is the DUT-side stage directly downstream of the driver. It holds a word-organised RAM with byte-lane writes and inserts a programmable number of wait states. It also produces the two-cycle AHB ERROR response for illegal or error-injected transfers.

## Interface
- `ADDR_BASE`, default 32'h0000_0000: byte address of word 0. Must be word-aligned.
- `DEPTH`, default 1024: number of 32-bit words. Power of two.
- `WAIT_STATES`, default 0: `hready_f`-low cycles per OKAY data phase. Range 0..15.
- `hclk_f` input 1: clock. All state is updated on the rising edge.
- `hreset_f` input 1: reset. Asynchronous, active-high.
- `hsel_f` input 1: slave select.
- `haddr_f` input 32: byte address.
- `htrans_f` input 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite_f` input 1: 1 = write.
- `hsize_f` input 3: 0 = byte, 1 = half, 2 = word. Values above 2 are illegal.
- `hburst_f` input 3: informational only; ignored.
- `hprot_f` input 4: informational only; ignored.
- `hwdata_f` input 32: write data, valid in the data phase.
- `error_f` input 1: error injection, sampled in the address phase.
- `hrdata_f` output 32: read data.
- `hready_f` output 1: transfer done. Single-slave system, so this is also the bus HREADY.
- `hresp_f` output 1: 0 = OKAY, 1 = ERROR.

## Operation
- **Accept:** an address phase is accepted on a rising edge where `hready_f`=1, `hsel_f`=1 and `htrans_f[1]`=1. On accept, the block registers addr, size and write, and classifies the transfer as OK or ERROR.
- **ERROR classification:** any of the following makes the transfer ERROR:
  - `hsize_f` > 2;
  - misalignment: half with `haddr_f[0]`=1, or word with `haddr_f[1:0]`≠0;
  - `haddr_f` outside the range ADDR_BASE to ADDR_BASE+4·DEPTH−1;
  - `error_f`=1.
- **IDLE/BUSY or `hsel_f`=0:** no data phase is created. Response is OKAY with zero wait.
- **FSM states:** IDLE, WAIT, ERR1, ERR2.
  - IDLE: `hready_f`=1, `hresp_f`=0.
    - Accept of an OK transfer with WAIT_STATES>0: go to WAIT with cnt=WAIT_STATES.
    - Accept of an OK transfer with WAIT_STATES=0: stay in IDLE. The next cycle is the completing data phase.
    - Accept of an ERROR transfer: go to ERR1.
  - WAIT: `hready_f`=0, `hresp_f`=0. cnt decrements each cycle; when cnt reaches 1, go to IDLE. WAIT therefore lasts exactly WAIT_STATES cycles.
  - ERR1: `hready_f`=0, `hresp_f`=1. Always goes to ERR2. Wait states are not applied to errors.
  - ERR2: `hready_f`=1, `hresp_f`=1. Accepts the next address exactly as IDLE does, then follows the same transitions as IDLE.
- **Write commit:** occurs on the edge that ends an OK write data phase (`hready_f`=1). Only the addressed byte lanes of `hwdata_f` are written, little-endian:
  - byte: lane `addr[1:0]`;
  - half: lanes `{addr[1],0}` and `{addr[1],1}`;
  - word: all four lanes.
- **ERROR transfers:** never write. `hrdata_f`=0 during ERR1/ERR2.
- **Read capture:** the word is captured into the `hrdata_f` register on the accept edge. If a write commits on that same edge to the same word, the captured value is the merged post-write value (forwarding). Reads always return the full 32-bit word regardless of size.
- **hrdata_f hold:** holds its value until the next read accept or an ERROR entry. It is zeroed on entry to ERR1.
- **RAM contents:** not reset; initial contents are undefined.
- **Pipelining:** an address phase presented during a completing data phase (IDLE or ERR2 with a pending transfer) is accepted on the same edge.

## Timing
- **Reset values:** `hready_f`=1, `hresp_f`=0, `hrdata_f`=0, state=IDLE, cnt=0, pending transfer cleared.
- **Reset mid-operation:** takes effect asynchronously. Any pending write is dropped, and RAM contents are preserved.
- **OK data phase length:** WAIT_STATES+1 cycles.
- **ERROR data phase length:** 2 cycles, `hready_f`=0 then 1, with `hresp_f`=1 on both.
- **Read data availability:** `hrdata_f` is valid from the first data-phase cycle and remains stable through the completing cycle.
- **Back-to-back throughput:** with WAIT_STATES=0, back-to-back transfers complete one per cycle.
- **Ignored during waits:** address, control and `error_f` are not sampled while `hready_f`=0.

## Test plan
- **Reset:** assert `hreset_f` for 3 cycles → `hready_f`=1, `hresp_f`=0, `hrdata_f`=0 while reset is high and on the first cycle after release.
- **Write then read, no waits:** WAIT_STATES=0. Word write 0xDEADBEEF to 0x10, immediately followed by a NONSEQ word read of 0x10 → read data phase returns 0xDEADBEEF (forwarding path); `hready_f` stays 1 throughout.
- **Byte write merge:** after the previous scenario, byte write to 0x13 with `hwdata_f`=0xAA00_0000, then word read of 0x10 → 0xAAAD_BEEF. Half write 0x1234 at 0x10 (lanes 0–1) followed by a read → 0xAAAD_1234.
- **Wait states:** WAIT_STATES=2, word read of 0x10 → `hready_f` reads 0, 0, 1 across the data phase; `hrdata_f` correct by the final cycle; the next address is accepted only on the edge where `hready_f`=1.
- **Error responses:**
  - word read at 0x1000 with DEPTH=1024 → cycle 1: `hready_f`=0, `hresp_f`=1; cycle 2: `hready_f`=1, `hresp_f`=1.
  - misaligned word write at 0x2 → same two-cycle ERROR; RAM unchanged.
  - `error_f`=1 on an in-range read → same two-cycle ERROR.
  - `hsize_f`=3 → same two-cycle ERROR.
- **Reset mid-wait:** WAIT_STATES=3, word write 0x5555_5555 to 0x20; assert `hreset_f` in the second wait cycle → `hready_f`=1 immediately; a subsequent read of 0x20 returns the pre-write value.
